// File: rtl/mips_exec_pkg.sv
// Shared types for the MIPS execute stage: ALU opcodes, mul/div opcodes and
// the iterative unit's state encoding.
package mips_exec_pkg;

    localparam int DEF_DATA_W = 32;

    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd6,
        ALU_SLT = 4'd7,
        ALU_NOR = 4'd12
    } alu_op_t;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIVU  = 3'd2,
        MD_MFHI  = 3'd3,
        MD_MFLO  = 3'd4
    } md_op_t;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/iterative_muldiv.sv
// Iterative unsigned multiply/divide with HI/LO, one bit per cycle.
// Divider present only when EXEC_DIVIDER_EN is defined.
module iterative_muldiv
    import mips_exec_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              busy_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int CNT_W = $clog2(DATA_W);

    md_state_t           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   opnd_q, opnd_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [DATA_W-1:0]   mul_add;
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] step_val;
`ifdef EXEC_DIVIDER_EN
    logic                isdiv_q, isdiv_d;
    logic [DATA_W:0]     div_shift, div_diff;
    logic                div_ge;
`endif

    // acc holds {partial product, multiplier} or {remainder, quotient/dividend}
    always_comb begin
        mul_add  = acc_q[0] ? opnd_q : '0;
        mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, mul_add};
        step_val = {mul_sum, acc_q[DATA_W-1:1]};
`ifdef EXEC_DIVIDER_EN
        div_shift = acc_q[2*DATA_W-1:DATA_W-1];
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_diff  = div_shift - {1'b0, opnd_q};
        if (isdiv_q) begin
            step_val = div_ge ? {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1}
                              : {div_shift[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef EXEC_DIVIDER_EN
        isdiv_d = isdiv_q;
`endif
        case (state_q)
            MD_IDLE: begin
                if (start_i && (op_i == MD_MULTU)) begin
                    acc_d   = {{DATA_W{1'b0}}, b_i};
                    opnd_d  = a_i;
                    cnt_d   = CNT_W'(DATA_W - 1);
                    state_d = MD_BUSY;
`ifdef EXEC_DIVIDER_EN
                    isdiv_d = 1'b0;
                end else if (start_i && (op_i == MD_DIVU)) begin
                    // divide by zero falls out naturally: quotient all ones, remainder = A
                    acc_d   = {{DATA_W{1'b0}}, a_i};
                    opnd_d  = b_i;
                    cnt_d   = CNT_W'(DATA_W - 1);
                    state_d = MD_BUSY;
                    isdiv_d = 1'b1;
`endif
                end
            end
            MD_BUSY: begin
                acc_d = step_val;
                if (cnt_q == '0) begin
                    hi_d    = step_val[2*DATA_W-1:DATA_W];
                    lo_d    = step_val[DATA_W-1:0];
                    state_d = MD_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef EXEC_DIVIDER_EN
            isdiv_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef EXEC_DIVIDER_EN
            isdiv_q <= isdiv_d;
`endif
        end
    end

    assign busy_o = (state_q == MD_BUSY);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: rtl/execute_stage_muldiv.sv
// MIPS EX stage: forwarding, ALU, branch resolution, iterative MULTU/DIVU with
// HI/LO and a ready stall toward Decode. DIVU enabled by EXEC_DIVIDER_EN.
module execute_stage_muldiv
    import mips_exec_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int REG_ADDR_W   = 5,
    parameter int BRANCH_SHIFT = 2
) (
    input  logic                  clock,
    input  logic                  resetMachine,
    input  logic                  valid_Decode,
    output logic                  ready_Execute,
    input  logic [3:0]            aluOp_Decode,
    input  logic [2:0]            mdOp_Decode,
    input  logic [DATA_W-1:0]     dataA_Decode,
    input  logic [DATA_W-1:0]     dataB_Decode,
    input  logic [DATA_W-1:0]     fwdAData_Forward,
    input  logic                  fwdASel_Forward,
    input  logic [DATA_W-1:0]     fwdBData_Forward,
    input  logic                  fwdBSel_Forward,
    input  logic [DATA_W-1:0]     immediate_Decode,
    input  logic                  useImm_Decode,
    input  logic                  branch_Decode,
    input  logic [DATA_W-1:0]     pcPlus4_Decode,
    input  logic                  wrEn_Decode,
    input  logic [REG_ADDR_W-1:0] wrAddr_Decode,
    input  logic                  memRead_Decode,
    input  logic                  memWrite_Decode,
    input  logic                  memToReg_Decode,
    output logic                  branchTaken_Execute,
    output logic [DATA_W-1:0]     branchTarget_Execute,
    output logic                  valid_Execute,
    output logic [DATA_W-1:0]     result_Execute,
    output logic [DATA_W-1:0]     storeData_Execute,
    output logic                  wrEn_Execute,
    output logic [REG_ADDR_W-1:0] wrAddr_Execute,
    output logic                  memRead_Execute,
    output logic                  memWrite_Execute,
    output logic                  memToReg_Execute
);

    alu_op_t             alu_op;
    md_op_t              md_op;
    logic [DATA_W-1:0]   op_a, op_bf, op_b, alu_res, md_hi, md_lo, br_diff;
    logic                accept, md_busy, is_md;

    logic                  valid_q, valid_d;
    logic [DATA_W-1:0]     result_q, result_d;
    logic [DATA_W-1:0]     store_q, store_d;
    logic                  wr_en_q, wr_en_d;
    logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic                  mem_rd_q, mem_rd_d;
    logic                  mem_wr_q, mem_wr_d;
    logic                  mem2reg_q, mem2reg_d;

    assign alu_op        = alu_op_t'(aluOp_Decode);
    assign md_op         = md_op_t'(mdOp_Decode);
    assign ready_Execute = !md_busy;
    assign accept        = valid_Decode & ready_Execute;
    assign is_md         = (md_op == MD_MULTU) || (md_op == MD_DIVU);

    assign op_a  = fwdASel_Forward ? fwdAData_Forward : dataA_Decode;
    assign op_bf = fwdBSel_Forward ? fwdBData_Forward : dataB_Decode;
    assign op_b  = useImm_Decode ? immediate_Decode : op_bf;

    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_AND: alu_res = op_a & op_b;
            ALU_OR:  alu_res = op_a | op_b;
            ALU_ADD: alu_res = op_a + op_b;
            ALU_SUB: alu_res = op_a - op_b;
            ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_NOR: alu_res = ~(op_a | op_b);
            default: alu_res = '0;
        endcase
    end

    assign br_diff              = op_a - op_b;
    assign branchTaken_Execute  = accept & branch_Decode & (br_diff == '0);
    assign branchTarget_Execute = branchTaken_Execute
                                ? pcPlus4_Decode + (immediate_Decode << BRANCH_SHIFT) : '0;

    iterative_muldiv #(
        .DATA_W (DATA_W)
    ) u_muldiv (
        .clk_i   (clock),
        .rst_i   (resetMachine),
        .start_i (accept & is_md),
        .op_i    (mdOp_Decode),
        .a_i     (op_a),
        .b_i     (op_b),
        .busy_o  (md_busy),
        .hi_o    (md_hi),
        .lo_o    (md_lo)
    );

    // EX/MEM next state: a bubble unless an instruction is accepted this cycle
    always_comb begin
        valid_d   = 1'b0;
        result_d  = '0;
        store_d   = '0;
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        mem_rd_d  = 1'b0;
        mem_wr_d  = 1'b0;
        mem2reg_d = 1'b0;
        if (accept) begin
            valid_d   = 1'b1;
            store_d   = op_bf;
            wr_addr_d = wrAddr_Decode;
            wr_en_d   = wrEn_Decode & !is_md;
            mem_rd_d  = memRead_Decode & !is_md;
            mem_wr_d  = memWrite_Decode & !is_md;
            mem2reg_d = memToReg_Decode & !is_md;
            if (md_op == MD_MFHI)      result_d = md_hi;
            else if (md_op == MD_MFLO) result_d = md_lo;
            else if (!is_md)           result_d = alu_res;
        end
    end

    always_ff @(posedge clock) begin
        if (resetMachine) begin
            valid_q   <= 1'b0;
            result_q  <= '0;
            store_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            mem2reg_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            result_q  <= result_d;
            store_q   <= store_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            mem_rd_q  <= mem_rd_d;
            mem_wr_q  <= mem_wr_d;
            mem2reg_q <= mem2reg_d;
        end
    end

    assign valid_Execute     = valid_q;
    assign result_Execute    = result_q;
    assign storeData_Execute = store_q;
    assign wrEn_Execute      = wr_en_q;
    assign wrAddr_Execute    = wr_addr_q;
    assign memRead_Execute   = mem_rd_q;
    assign memWrite_Execute  = mem_wr_q;
    assign memToReg_Execute  = mem2reg_q;

endmodule

// File: tb/tb_execute_stage_muldiv.sv
// Directed bench for execute_stage_muldiv: ALU vector table plus hand-written
// mul/div, branch and reset sequences. Expectations follow EXEC_DIVIDER_EN.
module tb_execute_stage_muldiv;
    import mips_exec_pkg::*;

    localparam int OW = 74;

    logic        clock = 1'b0;
    logic        resetMachine, valid_Decode, ready_Execute;
    logic [3:0]  aluOp_Decode;
    logic [2:0]  mdOp_Decode;
    logic [31:0] dataA_Decode, dataB_Decode, fwdAData_Forward, fwdBData_Forward;
    logic        fwdASel_Forward, fwdBSel_Forward, useImm_Decode, branch_Decode;
    logic [31:0] immediate_Decode, pcPlus4_Decode;
    logic        wrEn_Decode, memRead_Decode, memWrite_Decode, memToReg_Decode;
    logic [4:0]  wrAddr_Decode;
    logic        branchTaken_Execute, valid_Execute;
    logic [31:0] branchTarget_Execute, result_Execute, storeData_Execute;
    logic        wrEn_Execute, memRead_Execute, memWrite_Execute, memToReg_Execute;
    logic [4:0]  wrAddr_Execute;

    int n_vec = 0;
    int n_fail = 0;

    execute_stage_muldiv dut (
        .clock(clock), .resetMachine(resetMachine),
        .valid_Decode(valid_Decode), .ready_Execute(ready_Execute),
        .aluOp_Decode(aluOp_Decode), .mdOp_Decode(mdOp_Decode),
        .dataA_Decode(dataA_Decode), .dataB_Decode(dataB_Decode),
        .fwdAData_Forward(fwdAData_Forward), .fwdASel_Forward(fwdASel_Forward),
        .fwdBData_Forward(fwdBData_Forward), .fwdBSel_Forward(fwdBSel_Forward),
        .immediate_Decode(immediate_Decode), .useImm_Decode(useImm_Decode),
        .branch_Decode(branch_Decode), .pcPlus4_Decode(pcPlus4_Decode),
        .wrEn_Decode(wrEn_Decode), .wrAddr_Decode(wrAddr_Decode),
        .memRead_Decode(memRead_Decode), .memWrite_Decode(memWrite_Decode),
        .memToReg_Decode(memToReg_Decode),
        .branchTaken_Execute(branchTaken_Execute), .branchTarget_Execute(branchTarget_Execute),
        .valid_Execute(valid_Execute), .result_Execute(result_Execute),
        .storeData_Execute(storeData_Execute), .wrEn_Execute(wrEn_Execute),
        .wrAddr_Execute(wrAddr_Execute), .memRead_Execute(memRead_Execute),
        .memWrite_Execute(memWrite_Execute), .memToReg_Execute(memToReg_Execute)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, fa;
        logic        fas;
        logic [31:0] b, fb;
        logic        fbs;
        logic [31:0] imm;
        logic        ui;
        logic [4:0]  wa;
        logic        we, mr, mw, mt;
        logic [31:0] er, es;
    } vec_t;

    vec_t tbl [9];

    function automatic logic [OW-1:0] outs();
        return {valid_Execute, result_Execute, storeData_Execute, wrEn_Execute,
                wrAddr_Execute, memRead_Execute, memWrite_Execute, memToReg_Execute};
    endfunction

    task automatic check_o(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_w(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        valid_Decode = 0; aluOp_Decode = ALU_AND; mdOp_Decode = MD_NONE;
        dataA_Decode = 0; dataB_Decode = 0; fwdAData_Forward = 0; fwdBData_Forward = 0;
        fwdASel_Forward = 0; fwdBSel_Forward = 0; immediate_Decode = 0; useImm_Decode = 0;
        branch_Decode = 0; pcPlus4_Decode = 0; wrEn_Decode = 0; wrAddr_Decode = 0;
        memRead_Decode = 0; memWrite_Decode = 0; memToReg_Decode = 0;
    endtask

    task automatic md_issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        clear_in();
        valid_Decode = 1; mdOp_Decode = op; dataA_Decode = a; dataB_Decode = b;
        wrEn_Decode = 1; memRead_Decode = 1; memWrite_Decode = 1; wrAddr_Decode = 5'd9;
        step();
        check_w("md_accept_ctl", {28'd0, valid_Execute, wrEn_Execute, memRead_Execute, memWrite_Execute},
                32'h8);
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (!ready_Execute && cyc < 100) begin
            cyc++;
            if (cyc == 3)
                check_w("busy_bubble", {28'd0, valid_Execute, wrEn_Execute, memRead_Execute,
                        memWrite_Execute}, 32'h0);
            step();
        end
    endtask

    task automatic rd(input logic [2:0] op, input string nm, input logic [31:0] exp);
        clear_in();
        valid_Decode = 1; mdOp_Decode = op; wrEn_Decode = 1; wrAddr_Decode = 5'd2;
        step();
        check_w(nm, result_Execute, exp);
    endtask

    initial begin
        int cyc;
        tbl[0] = '{ALU_ADD, 32'd99, 32'd5, 1'b1, 32'd7, 32'd0, 1'b0, 32'd0, 1'b0, 5'd3, 1, 0, 0, 0, 32'd12, 32'd7};
        tbl[1] = '{ALU_SUB, 32'd10, 32'd0, 1'b0, 32'd3, 32'd0, 1'b0, 32'd0, 1'b0, 5'd4, 1, 0, 0, 0, 32'd7, 32'd3};
        tbl[2] = '{ALU_AND, 32'hF0F0, 32'd0, 1'b0, 32'hFF00, 32'd0, 1'b0, 32'd0, 1'b0, 5'd5, 1, 0, 0, 0, 32'hF000, 32'hFF00};
        tbl[3] = '{ALU_OR, 32'hF0F0, 32'd0, 1'b0, 32'hFF00, 32'd0, 1'b0, 32'd0, 1'b0, 5'd6, 1, 0, 0, 0, 32'hFFF0, 32'hFF00};
        tbl[4] = '{ALU_SLT, 32'hFFFFFFFF, 32'd0, 1'b0, 32'd1, 32'd0, 1'b0, 32'd0, 1'b0, 5'd7, 1, 0, 0, 0, 32'd1, 32'd1};
        tbl[5] = '{ALU_NOR, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd8, 1, 0, 0, 0, 32'hFFFFFFFF, 32'd0};
        tbl[6] = '{ALU_ADD, 32'h10, 32'd0, 1'b0, 32'h55, 32'd0, 1'b0, 32'hFFFFFFFF, 1'b1, 5'd9, 1, 1, 0, 1, 32'hF, 32'h55};
        tbl[7] = '{ALU_ADD, 32'hFFFFFFFF, 32'd0, 1'b0, 32'd2, 32'd0, 1'b0, 32'd0, 1'b0, 5'd10, 1, 0, 0, 0, 32'd1, 32'd2};
        tbl[8] = '{ALU_SUB, 32'd2, 32'd0, 1'b0, 32'd1, 32'h20, 1'b1, 32'd0, 1'b0, 5'd11, 0, 0, 1, 0, 32'hFFFFFFE2, 32'h20};

        clear_in();
        resetMachine = 1;
        step(); step();
        check_o("reset_outs", outs(), '0);
        check_w("reset_ready", {31'd0, ready_Execute}, 32'd1);
        resetMachine = 0;

        foreach (tbl[i]) begin
            clear_in();
            valid_Decode = 1; aluOp_Decode = tbl[i].op;
            dataA_Decode = tbl[i].a; fwdAData_Forward = tbl[i].fa; fwdASel_Forward = tbl[i].fas;
            dataB_Decode = tbl[i].b; fwdBData_Forward = tbl[i].fb; fwdBSel_Forward = tbl[i].fbs;
            immediate_Decode = tbl[i].imm; useImm_Decode = tbl[i].ui; wrAddr_Decode = tbl[i].wa;
            wrEn_Decode = tbl[i].we; memRead_Decode = tbl[i].mr;
            memWrite_Decode = tbl[i].mw; memToReg_Decode = tbl[i].mt;
            step();
            check_o($sformatf("alu_vec%0d", i), outs(),
                    {1'b1, tbl[i].er, tbl[i].es, tbl[i].we, tbl[i].wa, tbl[i].mr, tbl[i].mw, tbl[i].mt});
        end

        // idle cycle loads a bubble
        clear_in();
        step();
        check_w("idle_bubble", {31'd0, valid_Execute}, 32'd0);

        // reset mid-traffic, two cycles
        valid_Decode = 1; aluOp_Decode = ALU_ADD; dataA_Decode = 1; dataB_Decode = 2;
        wrEn_Decode = 1; wrAddr_Decode = 5'd3;
        step();
        resetMachine = 1;
        step(); step();
        check_o("midreset_outs", outs(), '0);
        check_w("midreset_ready", {31'd0, ready_Execute}, 32'd1);
        resetMachine = 0;

        // branch resolution in IDLE
        clear_in();
        valid_Decode = 1; branch_Decode = 1; aluOp_Decode = ALU_SUB;
        dataA_Decode = 3; dataB_Decode = 3; pcPlus4_Decode = 32'h100; immediate_Decode = 4;
        #1;
        check_w("beq_taken", {31'd0, branchTaken_Execute}, 32'd1);
        check_w("beq_target", branchTarget_Execute, 32'h110);
        dataB_Decode = 4;
        #1;
        check_w("beq_nt_taken", {31'd0, branchTaken_Execute}, 32'd0);
        check_w("beq_nt_target", branchTarget_Execute, 32'd0);
        step();

        // MULTU 0xFFFFFFFF * 2, BEQ presented while busy
        md_issue(MD_MULTU, 32'hFFFFFFFF, 32'd2);
        clear_in();
        valid_Decode = 1; branch_Decode = 1; aluOp_Decode = ALU_SUB;
        dataA_Decode = 3; dataB_Decode = 3; pcPlus4_Decode = 32'h100; immediate_Decode = 4;
        #1;
        check_w("beq_busy_taken", {31'd0, branchTaken_Execute}, 32'd0);
        check_w("beq_busy_target", branchTarget_Execute, 32'd0);
        wait_ready(cyc);
        check_w("mul_stall_cycles", cyc, 32'd32);
        rd(MD_MFHI, "mul_hi", 32'd1);
        rd(MD_MFLO, "mul_lo", 32'hFFFFFFFE);

`ifdef EXEC_DIVIDER_EN
        md_issue(MD_DIVU, 32'd100, 32'd7);
        wait_ready(cyc);
        check_w("div_stall_cycles", cyc, 32'd32);
        rd(MD_MFLO, "div_lo", 32'd14);
        rd(MD_MFHI, "div_hi", 32'd2);
        md_issue(MD_DIVU, 32'd9, 32'd0);
        wait_ready(cyc);
        check_w("div0_stall_cycles", cyc, 32'd32);
        rd(MD_MFLO, "div0_lo", 32'hFFFFFFFF);
        rd(MD_MFHI, "div0_hi", 32'd9);
`else
        md_issue(MD_DIVU, 32'd100, 32'd7);
        check_w("divu_nostall", {31'd0, ready_Execute}, 32'd1);
        rd(MD_MFLO, "divu_lo_kept", 32'hFFFFFFFE);
        rd(MD_MFHI, "divu_hi_kept", 32'd1);
        md_issue(MD_DIVU, 32'd9, 32'd0);
        check_w("divu0_nostall", {31'd0, ready_Execute}, 32'd1);
        rd(MD_MFLO, "divu0_lo_kept", 32'hFFFFFFFE);
`endif

        // reset in the middle of a MULTU abandons it and clears HI/LO
        md_issue(MD_MULTU, 32'd3, 32'd5);
        clear_in();
        for (int k = 0; k < 9; k++) step();
        check_w("pre_rst_busy", {31'd0, ready_Execute}, 32'd0);
        resetMachine = 1;
        step();
        resetMachine = 0;
        check_w("rst_busy_ready", {31'd0, ready_Execute}, 32'd1);
        rd(MD_MFLO, "rst_busy_lo", 32'd0);
        rd(MD_MFHI, "rst_busy_hi", 32'd0);

        // a fresh MULTU after the abort runs to completion
        md_issue(MD_MULTU, 32'd3, 32'd5);
        wait_ready(cyc);
        check_w("mul2_stall_cycles", cyc, 32'd32);
        rd(MD_MFLO, "mul2_lo", 32'd15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
